// File: rtl/pwm_capture.sv
// Recovers duty (high-cycle count) and period from an asynchronous PWM line.
// Emits one result per period, plus a stuck result when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int          PWM_INTERVAL = 1200,
  parameter int          TIMEOUT      = 1800,
  parameter int          WIDTH        = 11,
  parameter bit          ACTIVE_LOW   = 1'b0,
  localparam int         CNT_W        = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stuck,
  output logic             locked
);

  localparam int unsigned DUTY_MAX = (2 ** WIDTH) - 1;

  typedef enum logic {SEEK, MEASURE} state_t;

  state_t           state;
  logic             sync1, sync2, s_prev;
  logic             s, rise, timeout, per_match;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [1:0]       match_cnt, match_inc;

  function automatic logic [WIDTH-1:0] sat_duty(input int unsigned v);
    return (v > DUTY_MAX) ? WIDTH'(DUTY_MAX) : WIDTH'(v);
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    s         = sync2 ^ ACTIVE_LOW;
    rise      = s & ~s_prev;
    timeout   = (per_cnt == CNT_W'(TIMEOUT - 1));
    per_match = (per_cnt == CNT_W'(PWM_INTERVAL));
    match_inc = (match_cnt == 2'd2) ? 2'd2 : match_cnt + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEEK;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      s_prev     <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= 2'd0;
      duty_out   <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      s_prev <= s;
      valid  <= 1'b0;

      if (rise) begin
        // The first edge after SEEK only arms the counters; later edges close a period.
        if (state == MEASURE) begin
          duty_out   <= sat_duty(32'(hi_cnt));
          period_out <= per_cnt;
          stuck      <= 1'b0;
          valid      <= 1'b1;
          match_cnt  <= per_match ? match_inc : 2'd0;
          locked     <= per_match && (match_inc == 2'd2);
        end
        state   <= MEASURE;
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
      end else if (timeout) begin
        duty_out   <= s ? sat_duty(PWM_INTERVAL) : '0;
        period_out <= '0;
        stuck      <= 1'b1;
        valid      <= 1'b1;
        match_cnt  <= 2'd0;
        locked     <= 1'b0;
        state      <= SEEK;
        per_cnt    <= '0;
        hi_cnt     <= '0;
      end else begin
        per_cnt <= per_cnt + CNT_W'(1);
        if (state == MEASURE) hi_cnt <= hi_cnt + CNT_W'(s);
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a clocked PWM generator drives two instances
// (true and inverted polarity); expected results are queued and popped on valid.
module tb_pwm_capture;

  localparam int CNT_W = 11;
  localparam int WIDTH = 11;

  typedef struct {
    int duty;
    int period;
    bit stuck;
    bit locked;
    int gap;   // expected cycles since previous valid or reset release; 0 = unchecked
    bit dc;    // result consumed but not compared
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm = 1'b0;
  logic             pwm_n;
  logic [WIDTH-1:0] duty, duty_al;
  logic [CNT_W-1:0] period, period_al;
  logic             valid, valid_al, stuck, stuck_al, locked, locked_al;

  exp_t q[$];
  exp_t qa[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   mark_cyc = 0;
  int   last_valid = 0;
  bit   al_en = 1'b0;

  int   new_per = 1200, new_hi = 0, restart_ph = 0, restart_req = 0;

  assign pwm_n = ~pwm;

  pwm_capture u_dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm),
    .duty_out(duty), .period_out(period), .valid(valid), .stuck(stuck), .locked(locked)
  );

  pwm_capture #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_n),
    .duty_out(duty_al), .period_out(period_al), .valid(valid_al), .stuck(stuck_al),
    .locked(locked_al)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Generator: high while ph < cur_hi; new settings take effect at a period boundary or on restart.
  initial begin : gen
    int ph, cur_per, cur_hi, seen;
    ph = 0; cur_per = 1200; cur_hi = 0; seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (seen != restart_req) begin
        seen    = restart_req;
        cur_per = new_per;
        cur_hi  = new_hi;
        ph      = restart_ph;
      end else begin
        ph++;
        if (ph >= cur_per) begin
          ph      = 0;
          cur_per = new_per;
          cur_hi  = new_hi;
        end
      end
      pwm = (ph < cur_hi);
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        int   ref_cyc;
        e = q.pop_front();
        ref_cyc = (mark_cyc > last_valid) ? mark_cyc : last_valid;
        if (!e.dc) begin
          check("duty",   int'(duty),   e.duty);
          check("period", int'(period), e.period);
          check("stuck",  int'(stuck),  int'(e.stuck));
          check("locked", int'(locked), int'(e.locked));
          if (e.gap != 0) check("valid_gap", cyc - ref_cyc, e.gap);
        end
      end
      last_valid <= cyc;
    end
    if (rst_n && al_en && valid_al) begin
      if (qa.size() == 0) begin
        check("al_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if (!e.dc) begin
          check("al_duty",   int'(duty_al),   e.duty);
          check("al_period", int'(period_al), e.period);
          check("al_stuck",  int'(stuck_al),  int'(e.stuck));
          check("al_locked", int'(locked_al), int'(e.locked));
        end
      end
    end
  end

  task automatic push(input int d, input int p, input bit s, input bit l, input int gap);
    q.push_back('{duty: d, period: p, stuck: s, locked: l, gap: gap, dc: 1'b0});
  endtask

  task automatic push_al(input int d, input int p, input bit s, input bit l, input bit dc);
    qa.push_back('{duty: d, period: p, stuck: s, locked: l, gap: 0, dc: dc});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_duty"},   int'(duty),   0);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_valid"},  int'(valid),  0);
    check({tag, "_stuck"},  int'(stuck),  0);
    check({tag, "_locked"}, int'(locked), 0);
  endtask

  // Reset both DUTs, restart the generator at phase ph0, release on a falling edge.
  task automatic reset_start(input int per, input int hi, input int ph0);
    rst_n      = 1'b0;
    new_per    = per;
    new_hi     = hi;
    restart_ph = ph0;
    restart_req++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    mark_cyc = cyc;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (q.size() != 0 || qa.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drained"}, q.size() + qa.size(), 0);
    q.delete();
    qa.delete();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    // Steady 300/1200: lock on second result
    reset_start(1200, 300, 1190);
    push(300, 1200, 1'b0, 1'b0, 0);
    push(300, 1200, 1'b0, 1'b1, 1200);
    push(300, 1200, 1'b0, 1'b1, 1200);
    drain("steady300", 5000);

    // Switch to 900 at the next period boundary; lock holds
    new_hi = 900;
    push(300, 1200, 1'b0, 1'b1, 1200);
    push(900, 1200, 1'b0, 1'b1, 1200);
    push(900, 1200, 1'b0, 1'b1, 1200);
    drain("switch900", 5000);

    // Constant low: stuck every TIMEOUT cycles, first at 1800 after release
    reset_start(1200, 0, 1190);
    push(0, 0, 1'b1, 1'b0, 1800);
    push(0, 0, 1'b1, 1'b0, 1800);
    drain("stuck_low", 5000);

    // Constant high: stuck at full interval, then recover to 600
    reset_start(1200, 1200, 1190);
    push(1200, 0, 1'b1, 1'b0, 0);
    drain("stuck_high", 3000);
    new_per    = 1200;
    new_hi     = 600;
    restart_ph = 0;
    restart_req++;
    push(600, 1200, 1'b0, 1'b0, 0);
    drain("recover600", 4000);

    // Inverted-polarity instance; its first result after reset spans a spurious arm
    al_en = 1'b1;
    reset_start(1200, 800, 1190);
    push(800, 1200, 1'b0, 1'b0, 0);
    push(800, 1200, 1'b0, 1'b1, 1200);
    push_al(0, 0, 1'b0, 1'b0, 1'b1);
    push_al(800, 1200, 1'b0, 1'b0, 1'b0);
    push_al(800, 1200, 1'b0, 1'b1, 1'b0);
    drain("active_low", 5000);
    al_en = 1'b0;

    // Off-nominal period: never locks
    reset_start(1000, 250, 990);
    push(250, 1000, 1'b0, 1'b0, 0);
    push(250, 1000, 1'b0, 1'b0, 1000);
    push(250, 1000, 1'b0, 1'b0, 1000);
    drain("period1000", 5000);

    // Reset mid-period: outputs clear at once, partial period discarded
    reset_start(1200, 300, 1190);
    push(300, 1200, 1'b0, 1'b0, 0);
    push(300, 1200, 1'b0, 1'b1, 1200);
    drain("pre_midreset", 5000);
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    mark_cyc = cyc;
    push(300, 1200, 1'b0, 1'b0, 0);
    push(300, 1200, 1'b0, 1'b1, 1200);
    drain("post_midreset", 5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
